// File: rtl/add_rr_arbiter.sv
// Shared registered W-bit adder with a round-robin arbiter over NREQ valid/ready requesters.
// Results carry the winning requester's ID and drain through a single-entry valid/ready register.
module add_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int W = 8,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_sum,
   output logic              res_carry,
   output logic [IDW-1:0]    res_id,
   output logic [15:0]       op_count
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_next;
   logic [IDW-1:0] winner;
   logic           found;
   logic           free;
   logic           transfer;
   logic [W-1:0]   a_sel;
   logic [W-1:0]   b_sel;
   logic [W:0]     sum_full;
   int             idx;

   // Scan from ptr upward with explicit wrap so NREQ need not be a power of two.
   // Grants are masked during reset so no requester sees a handshake it cannot complete.
   always_comb begin
      free = ~res_valid | res_ready;
      found = 1'b0;
      winner = '0;
      idx = 0;
      req_ready = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            winner = IDW'(idx);
         end
      end
      transfer = rst_n & free & found;
      if (transfer) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_comb begin
      a_sel = req_a[int'(winner)*W +: W];
      b_sel = req_b[int'(winner)*W +: W];
      sum_full = {1'b0, a_sel} + {1'b0, b_sel};
      ptr_next = (int'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
   end

   // A transfer refills the slot even while the old result drains in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_sum <= '0;
         res_carry <= 1'b0;
         res_id <= '0;
         op_count <= '0;
         ptr <= '0;
      end else if (transfer) begin
         {res_carry, res_sum} <= sum_full;
         res_id <= winner;
         res_valid <= 1'b1;
         op_count <= op_count + 16'd1;
         ptr <= ptr_next;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_add_rr_arbiter.sv
// Randomized self-checking bench for add_rr_arbiter against a cycle-level behavioural model.
// Directed phases reproduce reset, overflow, fairness, backpressure and mid-op reset scenarios.
module tb_add_rr_arbiter;

   localparam int NREQ = 4;
   localparam int W = 8;
   localparam int IDW = 2;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic              res_valid;
   logic              res_ready;
   logic [W-1:0]      res_sum;
   logic              res_carry;
   logic [IDW-1:0]    res_id;
   logic [15:0]       op_count;

   int tests_run = 0;
   int tests_failed = 0;

   bit          m_valid;
   logic [W-1:0] m_sum;
   bit          m_carry;
   int          m_id;
   int          m_count;
   int          m_ptr;

   add_rr_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_a(req_a),
      .req_b(req_b),
      .req_ready(req_ready),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_sum(res_sum),
      .res_carry(res_carry),
      .res_id(res_id),
      .op_count(op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Round-robin rule: first valid index found scanning ptr, ptr+1, ... modulo NREQ.
   function automatic int modelWinner(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   // Drive one cycle of inputs, compare everything against the model, then advance the model.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                                input logic [NREQ*W-1:0] b, input logic rr, input logic rn);
      int w;
      bit free;
      logic [NREQ-1:0] exp_ready;
      int total;
      @(negedge clk);
      req_valid = v;
      req_a = a;
      req_b = b;
      res_ready = rr;
      rst_n = rn;
      #1;
      free = !m_valid || rr;
      w = modelWinner(v, m_ptr);
      exp_ready = '0;
      if (rn && free && w >= 0) exp_ready[w] = 1'b1;
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("res_valid", 32'(res_valid), 32'(m_valid));
      checkOutput("res_sum", 32'(res_sum), 32'(m_sum));
      checkOutput("res_carry", 32'(res_carry), 32'(m_carry));
      checkOutput("res_id", 32'(res_id), 32'(m_id));
      checkOutput("op_count", 32'(op_count), 32'(m_count));
      @(posedge clk);
      if (!rn) begin
         m_valid = 0; m_sum = '0; m_carry = 0; m_id = 0; m_count = 0; m_ptr = 0;
      end else if (free && w >= 0) begin
         total = int'(a[w*W +: W]) + int'(b[w*W +: W]);
         m_sum = W'(total % 256);
         m_carry = (total >= 256);
         m_id = w;
         m_valid = 1;
         m_count = (m_count + 1) % 65536;
         m_ptr = (w + 1) % NREQ;
      end else if (rr) begin
         m_valid = 0;
      end
   endtask

   function automatic logic [NREQ*W-1:0] randOps();
      logic [NREQ*W-1:0] r;
      r = {$urandom};
      return r;
   endfunction

   initial begin
      logic [NREQ*W-1:0] av;
      logic [NREQ*W-1:0] bv;
      logic [W-1:0] held_sum;
      rst_n = 1'b0;
      req_valid = '1;
      req_a = '0;
      req_b = '0;
      res_ready = 1'b1;
      m_valid = 0; m_sum = '0; m_carry = 0; m_id = 0; m_count = 0; m_ptr = 0;

      applyStimulus('1, randOps(), randOps(), 1'b1, 1'b0);
      applyStimulus('1, randOps(), randOps(), 1'b1, 1'b0);

      av = '0; bv = '0;
      av[2*W +: W] = 8'h7F; bv[2*W +: W] = 8'h01;
      applyStimulus(4'b0100, av, bv, 1'b1, 1'b1);
      #2;
      checkOutput("single_sum", 32'(res_sum), 32'h80);
      checkOutput("single_carry", 32'(res_carry), 32'h0);
      checkOutput("single_id", 32'(res_id), 32'd2);
      checkOutput("single_count", 32'(op_count), 32'd1);

      av = '0; bv = '0;
      av[0 +: W] = 8'hFF; bv[0 +: W] = 8'h02;
      applyStimulus(4'b0001, av, bv, 1'b1, 1'b1);
      #2;
      checkOutput("ovf_sum", 32'(res_sum), 32'h01);
      checkOutput("ovf_carry", 32'(res_carry), 32'h1);

      applyStimulus('0, '0, '0, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         applyStimulus('1, randOps(), randOps(), 1'b1, 1'b1);
         #2;
         checkOutput("fair_id", 32'(res_id), 32'(k % NREQ));
      end

      applyStimulus('1, randOps(), randOps(), 1'b0, 1'b1);
      held_sum = res_sum;
      for (int k = 0; k < 3; k++) begin
         applyStimulus('1, randOps(), randOps(), 1'b0, 1'b1);
         checkOutput("bp_hold", 32'(res_sum), 32'(held_sum));
      end
      applyStimulus('1, randOps(), randOps(), 1'b1, 1'b1);

      applyStimulus(4'b0010, randOps(), randOps(), 1'b0, 1'b1);
      applyStimulus(4'b0000, randOps(), randOps(), 1'b0, 1'b0);
      #2;
      checkOutput("midrst_valid", 32'(res_valid), 32'h0);
      applyStimulus(4'b1010, randOps(), randOps(), 1'b1, 1'b1);
      #2;
      checkOutput("midrst_first_id", 32'(res_id), 32'd1);

      for (int n = 0; n < 400; n++) begin
         applyStimulus(NREQ'($urandom), randOps(), randOps(),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
